link_credit_tx: RTL and testbench

//  Link transmitter on a router output port. Drains the local output fifo (drives read, consumes

---
 rtl/link_credit_tx_pkg.sv | 19 +
 rtl/link_credit_tx_credit_counter.sv | 43 ++++
 rtl/link_credit_tx.sv | 137 +++++++++++++
 tb/tb_link_credit_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/link_credit_tx_pkg.sv
// Shared NoC link definitions: flit geometry, default credit depth and
// link transmitter state encodings.
package link_credit_tx_pkg;

   localparam int HDR_SZ  = 4;
   localparam int PL_SZ   = 8;
   localparam int ADDR_SZ = 4;
   localparam int FLIT_SZ = HDR_SZ + PL_SZ + ADDR_SZ;

   localparam int FIFO_LOG2    = 2;
   localparam int CRED_MAX_DEF = 1 << FIFO_LOG2;

   typedef enum logic [1:0] {
      LTX_RUN    = 2'd0,
      LTX_DRAIN  = 2'd1,
      LTX_HALTED = 2'd2
   } ltx_state_e;

endpackage

// File: rtl/link_credit_tx_credit_counter.sv
// Saturating up/down credit counter; sat pulses when an increment
// arrives while the count already sits at MAX.
module credit_counter #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic         sat,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      sat     = 1'b0;
      if (inc && !dec) begin
         if (count_q == MAX_V) begin
            sat = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end else if (dec && !inc && count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= MAX_V;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/link_credit_tx.sv
// Credit-based link transmitter with halt/drain handshake.
// Optional LINK_CREDIT_TX_STATS_EN adds flit_cnt/stall_cnt outputs.
module link_credit_tx
   import link_credit_tx_pkg::*;
#(
   parameter int routerid = -1,
   parameter int CRED_MAX = CRED_MAX_DEF,
   parameter int CRED_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fifo_empty,
   input  logic [FLIT_SZ-1:0] fifo_item,
   output logic               fifo_read,
   output logic               link_valid,
   output logic [FLIT_SZ-1:0] link_flit,
   input  logic               credit_in,
   input  logic               halt_req,
   output logic               halt_ack,
   output logic               credit_err,
   output logic [CRED_W-1:0]  credits
`ifdef LINK_CREDIT_TX_STATS_EN
   ,
   output logic [31:0]        flit_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   if (CRED_W < $clog2(CRED_MAX + 1) || routerid < -1) begin : g_cfg_err
      $error("link_credit_tx: bad parameters");
   end

   ltx_state_e         state_q, state_d;
   logic               link_valid_q, link_valid_d;
   logic [FLIT_SZ-1:0] link_flit_q, link_flit_d;
   logic               halt_ack_q, halt_ack_d;
   logic               credit_err_q, credit_err_d;
   logic [CRED_W-1:0]  cred;
   logic               sat;
   logic               send;
   logic               cred_full;

   credit_counter #(
      .MAX (CRED_MAX),
      .W   (CRED_W)
   ) u_cred (
      .clk   (clk),
      .rst_n (reset),
      .inc   (credit_in),
      .dec   (send),
      .sat   (sat),
      .count (cred)
   );

   assign cred_full = (cred == CRED_W'(CRED_MAX));

   // Halt is honoured in the very cycle it is sampled, before the FSM moves.
   assign send = reset && (state_q == LTX_RUN) && !halt_req
              && !fifo_empty && (cred != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LTX_RUN: begin
            if (halt_req) state_d = LTX_DRAIN;
         end
         LTX_DRAIN: begin
            if (!halt_req) begin
               state_d = LTX_RUN;
            end else if (cred_full && !link_valid_q) begin
               state_d = LTX_HALTED;
            end
         end
         LTX_HALTED: begin
            if (!halt_req) state_d = LTX_RUN;
         end
         default: state_d = LTX_RUN;
      endcase
   end

   always_comb begin
      link_valid_d = send;
      link_flit_d  = send ? fifo_item : link_flit_q;
      halt_ack_d   = (state_d == LTX_HALTED);
      credit_err_d = credit_err_q | sat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= LTX_RUN;
         link_valid_q <= 1'b0;
         link_flit_q  <= '0;
         halt_ack_q   <= 1'b0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         link_valid_q <= link_valid_d;
         link_flit_q  <= link_flit_d;
         halt_ack_q   <= halt_ack_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign fifo_read  = send;
   assign link_valid = link_valid_q;
   assign link_flit  = link_flit_q;
   assign halt_ack   = halt_ack_q;
   assign credit_err = credit_err_q;
   assign credits    = cred;

`ifdef LINK_CREDIT_TX_STATS_EN
   logic [31:0] flit_cnt_q, flit_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      flit_cnt_d  = flit_cnt_q + {31'd0, link_valid_q};
      stall_cnt_d = stall_cnt_q;
      if (state_q == LTX_RUN && !fifo_empty && cred == '0) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         flit_cnt_q  <= flit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign flit_cnt  = flit_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_link_credit_tx.sv
// Bench for link_credit_tx: local fifo and neighbour fifo modelled as
// queues; a transaction-level model predicts credits, pops and halt state.
module tb_link_credit_tx;
   import link_credit_tx_pkg::*;

   localparam int CMAX = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               fifo_empty = 1'b1;
   logic [FLIT_SZ-1:0] fifo_item = '0;
   logic               fifo_read;
   logic               link_valid;
   logic [FLIT_SZ-1:0] link_flit;
   logic               credit_in = 1'b0;
   logic               halt_req = 1'b0;
   logic               halt_ack;
   logic               credit_err;
   logic [2:0]         credits;
`ifdef LINK_CREDIT_TX_STATS_EN
   logic [31:0]        flit_cnt;
   logic [31:0]        stall_cnt;
`endif

   link_credit_tx #(.routerid(3), .CRED_MAX(CMAX), .CRED_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_item  (fifo_item),
      .fifo_read  (fifo_read),
      .link_valid (link_valid),
      .link_flit  (link_flit),
      .credit_in  (credit_in),
      .halt_req   (halt_req),
      .halt_ack   (halt_ack),
      .credit_err (credit_err),
      .credits    (credits)
`ifdef LINK_CREDIT_TX_STATS_EN
      ,
      .flit_cnt   (flit_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef enum {M_RUN, M_DRAIN, M_HALTED} mst_e;

   int total = 0;
   int bad = 0;

   logic [FLIT_SZ-1:0] lq[$];
   logic [FLIT_SZ-1:0] nq[$];
   mst_e               m_st = M_RUN;
   int                 m_cred = CMAX;
   bit                 m_valid = 0;
   logic [FLIT_SZ-1:0] m_flit = '0;
   bit                 m_err = 0;
   longint             m_flits = 0;
   longint             m_stall = 0;

   function automatic void chk(string n, longint a, longint e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
      end
   endfunction

   task automatic apply_reset();
      reset = 1'b0;
      halt_req = 1'b0;
      credit_in = 1'b0;
      fifo_empty = 1'b0;
      fifo_item = 16'hA5A5;
      #1;
      chk("rst_link_valid", link_valid, 0);
      chk("rst_fifo_read", fifo_read, 0);
      chk("rst_credits", credits, CMAX);
      chk("rst_halt_ack", halt_ack, 0);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_link_flit", link_flit, 0);
`ifdef LINK_CREDIT_TX_STATS_EN
      chk("rst_flit_cnt", flit_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      lq.delete();
      nq.delete();
      m_st = M_RUN;
      m_cred = CMAX;
      m_valid = 0;
      m_flit = '0;
      m_err = 0;
      m_flits = 0;
      m_stall = 0;
      @(negedge clk);
      fifo_empty = 1'b1;
      fifo_item = '0;
      reset = 1'b1;
   endtask

   task automatic cyc(input bit pop, input bit halt, input bit fc,
                      output bit o_rd, output int o_cred,
                      output bit o_v, output bit o_ack);
      bit es;
      bit cr;
      @(negedge clk);
      halt_req = halt;
      cr = fc || (pop && nq.size() > 0);
      credit_in = cr;
      fifo_empty = (lq.size() == 0);
      fifo_item = fifo_empty ? '0 : lq[0];
      #1;
      es = (m_st == M_RUN) && !halt && lq.size() > 0 && m_cred > 0;
      chk("fifo_read", fifo_read, es);
      chk("credits", credits, m_cred);
      o_rd = fifo_read;
      o_cred = int'(credits);
      if (m_st == M_RUN && lq.size() > 0 && m_cred == 0) m_stall++;
      if (pop && nq.size() > 0) void'(nq.pop_front());
      if (es) m_flit = lq[0];
      if (fifo_read && lq.size() > 0) void'(lq.pop_front());
      case (m_st)
         M_RUN:    if (halt) m_st = M_DRAIN;
         M_DRAIN:  if (!halt) m_st = M_RUN;
                   else if (m_cred == CMAX && !m_valid) m_st = M_HALTED;
         default:  if (!halt) m_st = M_RUN;
      endcase
      if (cr && !es) begin
         if (m_cred == CMAX) m_err = 1;
         else m_cred++;
      end else if (es && !cr) begin
         m_cred--;
      end
      m_valid = es;
      @(posedge clk);
      #1;
      chk("link_valid", link_valid, m_valid);
      chk("link_flit", link_flit, m_flit);
      chk("halt_ack", halt_ack, m_st == M_HALTED);
      chk("credit_err", credit_err, m_err);
      if (m_valid) m_flits++;
      if (link_valid) nq.push_back(link_flit);
      o_v = link_valid;
      o_ack = halt_ack;
   endtask

   typedef struct {
      int push;
      bit pop;
      bit halt;
      bit rd;
      int cred;
      bit v;
      bit ack;
   } vec_t;

   vec_t tbl[21];

   initial begin
      bit rd, v, ack;
      int cr;
      bit hold_halt;

      tbl[0]  = '{6, 0, 0, 1, 4, 1, 0};
      tbl[1]  = '{0, 0, 0, 1, 3, 1, 0};
      tbl[2]  = '{0, 0, 0, 1, 2, 1, 0};
      tbl[3]  = '{0, 0, 0, 1, 1, 1, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 0, 1, 1, 1, 0};
      tbl[8]  = '{0, 1, 0, 1, 1, 1, 0};
      tbl[9]  = '{0, 1, 0, 0, 1, 0, 0};
      tbl[10] = '{0, 1, 0, 0, 2, 0, 0};
      tbl[11] = '{0, 1, 0, 0, 3, 0, 0};
      tbl[12] = '{0, 1, 0, 0, 4, 0, 0};
      tbl[13] = '{3, 0, 0, 1, 4, 1, 0};
      tbl[14] = '{0, 0, 1, 0, 3, 0, 0};
      tbl[15] = '{0, 1, 1, 0, 3, 0, 0};
      tbl[16] = '{0, 0, 1, 0, 4, 0, 1};
      tbl[17] = '{0, 0, 1, 0, 4, 0, 1};
      tbl[18] = '{0, 0, 0, 0, 4, 0, 0};
      tbl[19] = '{0, 0, 0, 1, 4, 1, 0};
      tbl[20] = '{0, 0, 0, 1, 3, 1, 0};

      #2;
      apply_reset();

      for (int i = 0; i < 21; i++) begin
         for (int k = 0; k < tbl[i].push; k++) lq.push_back(FLIT_SZ'($urandom));
         cyc(tbl[i].pop, tbl[i].halt, 0, rd, cr, v, ack);
         chk($sformatf("t%0d_rd", i), rd, tbl[i].rd);
         chk($sformatf("t%0d_cred", i), cr, tbl[i].cred);
         chk($sformatf("t%0d_valid", i), v, tbl[i].v);
         chk($sformatf("t%0d_ack", i), ack, tbl[i].ack);
      end

      // spurious credit while full
      apply_reset();
      cyc(0, 0, 1, rd, cr, v, ack);
      chk("spur_credits", credits, CMAX);
      chk("spur_err", credit_err, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, rd, cr, v, ack);
      chk("spur_err_sticky", credit_err, 1);
      apply_reset();

      // randomized traffic
      hold_halt = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1 && lq.size() < 6)
            lq.push_back(FLIT_SZ'($urandom));
         if ($urandom_range(0, 19) == 0) hold_halt = !hold_halt;
         cyc($urandom_range(0, 9) < 6, hold_halt, 0, rd, cr, v, ack);
      end
      for (int i = 0; i < 30; i++) cyc(1, 0, 0, rd, cr, v, ack);
      chk("drain_credits", credits, CMAX);
      chk("rand_no_err", credit_err, 0);

      // reset mid-burst
      for (int k = 0; k < 5; k++) lq.push_back(FLIT_SZ'($urandom));
      cyc(0, 0, 0, rd, cr, v, ack);
      cyc(0, 0, 0, rd, cr, v, ack);
      chk("mid_valid_before", link_valid, 1);
`ifdef LINK_CREDIT_TX_STATS_EN
      chk("stats_flit_cnt", flit_cnt, m_flits);
      chk("stats_stall_cnt", stall_cnt, m_stall);
`endif
      #2;
      apply_reset();
      lq.push_back(16'h1234);
      cyc(0, 0, 0, rd, cr, v, ack);
      chk("post_rst_send", rd, 1);
      chk("post_rst_flit", link_flit, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
